uart_frame_recv: RTL and testbench

UART receiver and frame assembler for the servo-command link: the receive-side counterpart of our command transmitter. It deserialises 8N1 bytes from `uart_rxd` and collects fixed-length ASCII command frames such as `#000P1500T1000!`. It presents each complete, well-formed frame as one 120-bit word, using the same byte packing the transmitter consumes.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_byte_rx.sv | 110 +++++++++++
 rtl/uart_frame_recv.sv | 118 +++++++++++
 tb/tb_uart_frame_recv.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg -- frame delimiters, baud divisor and FSM state types for the servo-command UART receiver
// Rev 1.0
// ============================================================================
package uart_pkg;

   localparam logic [7:0] C_SOF = 8'h23;
   localparam logic [7:0] C_EOF = 8'h21;

   typedef enum logic [1:0] {
      B_IDLE  = 2'd0,
      B_START = 2'd1,
      B_DATA  = 2'd2,
      B_STOP  = 2'd3
   } byte_state_e;

   typedef enum logic [0:0] {
      F_WAIT_SOF = 1'b0,
      F_COLLECT  = 1'b1
   } frame_state_e;

   function automatic int bps_cnt(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// uart_byte_rx -- 8N1 deserialiser: synchroniser, start/data/stop sampling FSM
// Rev 1.0
// ============================================================================
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int BPS_CNT = 5208
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       rxd_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       stop_err_o
);

   localparam logic [15:0] C_HALF = 16'(BPS_CNT / 2 - 1);
   localparam logic [15:0] C_FULL = 16'(BPS_CNT - 1);

   logic        sync1_q;
   logic        sync2_q;
   logic        sync3_q;
   logic        w_fall;
   byte_state_e state_q;
   logic [15:0] clk_cnt_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shift_q;
   logic [7:0]  byte_q;
   logic        byte_valid_q;
   logic        stop_err_q;

   assign w_fall = sync3_q & ~sync2_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= B_IDLE;
         clk_cnt_q    <= 16'd0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'd0;
         byte_q       <= 8'd0;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
         case (state_q)
            B_IDLE: begin
               clk_cnt_q <= 16'd0;
               if (w_fall) state_q <= B_START;
            end
            B_START: begin
               // A line that is high again at mid-start-bit was only a glitch.
               if (clk_cnt_q == C_HALF) begin
                  clk_cnt_q <= 16'd0;
                  bit_idx_q <= 3'd0;
                  state_q   <= sync2_q ? B_IDLE : B_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 16'd1;
               end
            end
            B_DATA: begin
               if (clk_cnt_q == C_FULL) begin
                  clk_cnt_q <= 16'd0;
                  shift_q   <= {sync2_q, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) state_q <= B_STOP;
                  else                   bit_idx_q <= bit_idx_q + 3'd1;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 16'd1;
               end
            end
            B_STOP: begin
               // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
               if (clk_cnt_q == C_FULL) begin
                  clk_cnt_q <= 16'd0;
                  state_q   <= B_IDLE;
                  if (sync2_q) begin
                     byte_q       <= shift_q;
                     byte_valid_q <= 1'b1;
                  end else begin
                     stop_err_q   <= 1'b1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 16'd1;
               end
            end
            default: state_q <= B_IDLE;
         endcase
      end
   end

   assign byte_o       = byte_q;
   assign byte_valid_o = byte_valid_q;
   assign stop_err_o   = stop_err_q;

endmodule
`default_nettype wire

// File: rtl/uart_frame_recv.sv
`default_nettype none
// ============================================================================
// uart_frame_recv -- UART receiver assembling fixed-length SOF..EOF command frames
// Rev 1.0
// ============================================================================
module uart_frame_recv
   import uart_pkg::*;
#(
   parameter int         CLK_FREQ  = 50000000,
   parameter int         UART_BPS  = 9600,
   parameter int         FRAME_LEN = 15,
   parameter logic [7:0] SOF       = C_SOF,
   parameter logic [7:0] EOF       = C_EOF
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   uart_rxd,
   output logic [7:0]             rx_byte,
   output logic                   rx_byte_valid,
   output logic [FRAME_LEN*8-1:0] frame_data,
   output logic                   frame_valid,
   output logic                   frame_err
);

   localparam int         BPS    = bps_cnt(CLK_FREQ, UART_BPS);
   localparam logic [3:0] C_LAST = 4'(FRAME_LEN - 1);

   logic [7:0]             w_byte;
   logic                   w_byte_valid;
   logic                   w_stop_err;
   logic [FRAME_LEN*8-1:0] w_frame;

   frame_state_e           state_q;
   logic [3:0]             idx_q;
   logic [7:0]             shadow_q [FRAME_LEN-1];
   logic [FRAME_LEN*8-1:0] frame_q;
   logic                   frame_valid_q;
   logic                   frame_err_q;

   uart_byte_rx #(
      .BPS_CNT (BPS)
   ) u_byte_rx (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .rxd_i        (uart_rxd),
      .byte_o       (w_byte),
      .byte_valid_o (w_byte_valid),
      .stop_err_o   (w_stop_err)
   );

   // Completed frame: shadow bytes plus the EOF byte arriving this cycle.
   always_comb begin
      w_frame = '0;
      for (int k = 0; k < FRAME_LEN - 1; k++) w_frame[k*8 +: 8] = shadow_q[k];
      w_frame[FRAME_LEN*8-1 -: 8] = w_byte;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= F_WAIT_SOF;
         idx_q         <= 4'd0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         for (int k = 0; k < FRAME_LEN - 1; k++) shadow_q[k] <= 8'd0;
      end else begin
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         case (state_q)
            F_WAIT_SOF: begin
               if (w_byte_valid && (w_byte == SOF)) begin
                  shadow_q[0] <= w_byte;
                  idx_q       <= 4'd1;
                  state_q     <= F_COLLECT;
               end
            end
            F_COLLECT: begin
               if (w_stop_err) begin
                  frame_err_q <= 1'b1;
                  idx_q       <= 4'd0;
                  state_q     <= F_WAIT_SOF;
               end else if (w_byte_valid) begin
                  if (idx_q == C_LAST) begin
                     if (w_byte == EOF) begin
                        frame_q       <= w_frame;
                        frame_valid_q <= 1'b1;
                     end else begin
                        frame_err_q   <= 1'b1;
                     end
                     idx_q   <= 4'd0;
                     state_q <= F_WAIT_SOF;
                  end else if (w_byte == SOF) begin
                     frame_err_q <= 1'b1;
                     shadow_q[0] <= w_byte;
                     idx_q       <= 4'd1;
                  end else if (w_byte == EOF) begin
                     frame_err_q <= 1'b1;
                     idx_q       <= 4'd0;
                     state_q     <= F_WAIT_SOF;
                  end else begin
                     shadow_q[idx_q] <= w_byte;
                     idx_q           <= idx_q + 4'd1;
                  end
               end
            end
            default: state_q <= F_WAIT_SOF;
         endcase
      end
   end

   assign rx_byte       = w_byte;
   assign rx_byte_valid = w_byte_valid;
   assign frame_data    = frame_q;
   assign frame_valid   = frame_valid_q;
   assign frame_err     = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_recv.sv
`default_nettype none
// ============================================================================
// tb_uart_frame_recv -- directed bench for uart_frame_recv at 1 Mbaud (50 clocks per bit)
// Rev 1.0
// ============================================================================
module tb_uart_frame_recv;

   localparam int BPS = 50;

   logic         sys_clk;
   logic         sys_rst_n;
   logic         uart_rxd;
   logic [7:0]   rx_byte;
   logic         rx_byte_valid;
   logic [119:0] frame_data;
   logic         frame_valid;
   logic         frame_err;

   int n_cmp;
   int n_mis;
   int cyc;
   int n_rxv;
   int n_fv;
   int n_fe;
   int n_both;
   int last_v_cyc;
   int t_start;
   logic [7:0] last_byte;

   uart_frame_recv #(
      .CLK_FREQ  (50000000),
      .UART_BPS  (1000000),
      .FRAME_LEN (15),
      .SOF       (8'h23),
      .EOF       (8'h21)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .uart_rxd      (uart_rxd),
      .rx_byte       (rx_byte),
      .rx_byte_valid (rx_byte_valid),
      .frame_data    (frame_data),
      .frame_valid   (frame_valid),
      .frame_err     (frame_err)
   );

   initial sys_clk = 1'b0;
   always #10 sys_clk = ~sys_clk;

   initial cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   initial begin
      n_rxv = 0; n_fv = 0; n_fe = 0; n_both = 0; last_v_cyc = 0; last_byte = 8'h00;
   end
   always @(negedge sys_clk) begin
      if (rx_byte_valid) begin
         n_rxv      = n_rxv + 1;
         last_byte  = rx_byte;
         last_v_cyc = cyc;
      end
      if (frame_valid) n_fv = n_fv + 1;
      if (frame_err)   n_fe = n_fe + 1;
      if (frame_valid && frame_err) n_both = n_both + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_mis = n_mis + 1;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [119:0] pack(input string s);
      logic [119:0] v;
      v = '0;
      for (int k = 0; k < 15; k++) v[k*8 +: 8] = s[k];
      return v;
   endfunction

   task automatic line_bit(input logic v);
      uart_rxd = v;
      repeat (BPS) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
      t_start = cyc;
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
      line_bit(stop);
      uart_rxd = 1'b1;
      repeat (gap) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_str(input string s, input int bad);
      for (int k = 0; k < s.len(); k++)
         send_byte(s[k], (k != bad), (k == bad) ? 5 : 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   int b_rxv, b_fv, b_fe, lat;
   logic [119:0] f_prev;

   initial begin
      n_cmp = 0; n_mis = 0; t_start = 0;
      uart_rxd  = 1'b1;
      sys_rst_n = 1'b0;
      repeat (4) @(negedge sys_clk);
      chk("rst_rx_byte", rx_byte, 8'h00);
      chk("rst_rx_valid", rx_byte_valid, 1'b0);
      chk("rst_frame_data", frame_data, 120'h0);
      chk("rst_frame_valid", frame_valid, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      idle(10);

      // single byte, latency 3 + 25 + 450 + 1 = 479 +/- 1
      b_rxv = n_rxv;
      send_byte(8'hA5, 1'b1, 10);
      chk("a5_byte", last_byte, 8'hA5);
      chk("a5_count", n_rxv - b_rxv, 1);
      lat = last_v_cyc - t_start;
      chk("a5_latency_in_478_480", (lat >= 478 && lat <= 480), 1'b1);

      // complete frame, back to back
      b_fv = n_fv; b_fe = n_fe;
      send_str("#000P1500T1000!", -1);
      idle(20);
      chk("f1_valid_count", n_fv - b_fv, 1);
      chk("f1_err_count", n_fe - b_fe, 0);
      chk("f1_sof", frame_data[7:0], 8'h23);
      chk("f1_eof", frame_data[119:112], 8'h21);
      chk("f1_P", frame_data[39:32], 8'h50);
      chk("f1_all", frame_data, pack("#000P1500T1000!"));

      // 20-cycle low glitch, then a real byte
      b_rxv = n_rxv;
      uart_rxd = 1'b0;
      idle(20);
      uart_rxd = 1'b1;
      idle(80);
      chk("glitch_no_byte", n_rxv - b_rxv, 0);
      chk("glitch_idle", dut.u_byte_rx.state_q, 2'd0);
      send_byte(8'h3C, 1'b1, 10);
      chk("glitch_next_byte", last_byte, 8'h3C);
      chk("glitch_next_count", n_rxv - b_rxv, 1);

      // SOF restart mid-frame
      b_fv = n_fv; b_fe = n_fe;
      send_str("#000P15#", -1);
      idle(5);
      chk("restart_err_at_sof", n_fe - b_fe, 1);
      chk("restart_no_valid_yet", n_fv - b_fv, 0);
      send_str("000P1500T1000!", -1);
      idle(20);
      chk("restart_valid", n_fv - b_fv, 1);
      chk("restart_err_total", n_fe - b_fe, 1);
      chk("restart_data", frame_data, pack("#000P1500T1000!"));

      // framing error on byte 6, frame_data must hold
      f_prev = frame_data;
      b_fv = n_fv; b_fe = n_fe;
      send_str("#002P2000T0500!", 6);
      idle(20);
      chk("stoperr_err", n_fe - b_fe, 1);
      chk("stoperr_no_valid", n_fv - b_fv, 0);
      chk("stoperr_hold", frame_data, f_prev);
      send_str("#003P0900T2000!", -1);
      idle(20);
      chk("after_err_valid", n_fv - b_fv, 1);
      chk("after_err_data", frame_data, pack("#003P0900T2000!"));

      // reset during byte 8 of a frame
      send_str("#004P110", -1);
      uart_rxd = 1'b0;
      idle(75);
      sys_rst_n = 1'b0;
      uart_rxd  = 1'b1;
      repeat (2) @(negedge sys_clk);
      chk("midrst_rx_byte", rx_byte, 8'h00);
      chk("midrst_rx_valid", rx_byte_valid, 1'b0);
      chk("midrst_frame_data", frame_data, 120'h0);
      chk("midrst_frame_valid", frame_valid, 1'b0);
      chk("midrst_frame_err", frame_err, 1'b0);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      idle(20);
      b_fv = n_fv; b_fe = n_fe;
      send_str("#005P1300T0300!", -1);
      idle(20);
      chk("postrst_valid", n_fv - b_fv, 1);
      chk("postrst_no_err", n_fe - b_fe, 0);
      chk("postrst_data", frame_data, pack("#005P1300T0300!"));

      chk("valid_err_overlap", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
